// File: rtl/packet_arbiter_pkg.sv
// Shared definitions for packet_arbiter.
//   state_t      : two-state arbitration FSM (IDLE = no owner, LOCK = one owner)
//   DEF_NUM_SRC  : default number of byte sources
//   DEF_TIMEOUT  : default watchdog stall limit
package packet_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
   localparam int DEF_NUM_SRC = 4;
   localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker.
//   req  : request vector
//   last : index of the previous owner (search starts at last+1, wraps)
//   gnt  : one-hot winner, zero when no request
//   any  : at least one request present
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic          any
);
   logic [N-1:0] upper;
   logic [N-1:0] cand;

   always_comb begin
      // requests strictly above last get first pick; otherwise wrap to the
      // full vector, and the lowest set bit of the chosen set wins
      upper = '0;
      for (int k = 0; k < N; k++) upper[k] = (k > int'(last));
      cand = ((req & upper) != '0) ? (req & upper) : req;
      gnt  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (cand[k]) begin
            gnt    = '0;
            gnt[k] = 1'b1;
         end
      end
      any = |req;
   end
endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter: packet-level round-robin arbiter muxing NUM_SRC AXI-Stream
// byte sources onto one emitter. A source owns the output from grant until
// its tlast beat is accepted; one IDLE cycle separates consecutive packets.
//   i_clk, i_rst_n              : clock, async active-low reset
//   i_tdata/i_tlast/i_tvalid    : per-source stream inputs (source k at [8k+7:8k])
//   o_tready                    : per-source ready (only the owner's bit can be set)
//   o_tdata/o_tlast/o_tvalid    : stream to emitter, i_tready back from it
//   o_grant                     : one-hot owner, zero when idle
//   o_timeout                   : one-cycle pulse after a watchdog release
// Optional feature: define PACKET_ARBITER_WATCHDOG_EN to release an owner that
// holds tvalid low for TIMEOUT LOCK cycles without an accepted beat.
module packet_arbiter
   import packet_arbiter_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [8*NUM_SRC-1:0]   i_tdata,
   input  logic [NUM_SRC-1:0]     i_tlast,
   input  logic [NUM_SRC-1:0]     i_tvalid,
   output logic [NUM_SRC-1:0]     o_tready,
   output logic [7:0]             o_tdata,
   output logic                   o_tlast,
   output logic                   o_tvalid,
   input  logic                   i_tready,
   output logic [NUM_SRC-1:0]     o_grant,
   output logic                   o_timeout
);
   localparam int IW = $clog2(NUM_SRC);

   state_t              state;
   logic [IW-1:0]       last_owner;
   logic [IW-1:0]       owner_idx;
   logic [NUM_SRC-1:0]  pick;
   logic                pick_any;
   logic                accept;
   logic                release_lock;
   logic                wd_fire;

   rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
      .req  (i_tvalid),
      .last (last_owner),
      .gnt  (pick),
      .any  (pick_any)
   );

   // o_grant is zero in IDLE, so this AND-OR mux yields all-zero outputs there
   always_comb begin
      o_tdata   = '0;
      o_tlast   = 1'b0;
      o_tvalid  = 1'b0;
      owner_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (o_grant[k]) begin
            o_tdata   = i_tdata[8*k +: 8];
            o_tlast   = i_tlast[k];
            o_tvalid  = i_tvalid[k];
            owner_idx = IW'(k);
         end
      end
      o_tready = o_grant & {NUM_SRC{i_tready}};
   end

   assign accept       = o_tvalid & i_tready;
   assign release_lock = (accept & o_tlast) | wd_fire;

`ifdef PACKET_ARBITER_WATCHDOG_EN
   logic [15:0] wd_cnt;
   logic        stall;

   // only an owner with tvalid low counts; backpressure from the emitter does not
   assign stall   = (state == LOCK) && !o_tvalid;
   assign wd_fire = stall && (wd_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd_cnt    <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= wd_fire;
         if (state != LOCK || accept || wd_fire) wd_cnt <= '0;
         else if (stall)                         wd_cnt <= wd_cnt + 16'd1;
      end
   end
`else
   assign wd_fire   = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_grant    <= '0;
         last_owner <= IW'(NUM_SRC - 1);
      end else begin
         case (state)
            IDLE: if (pick_any) begin
               o_grant <= pick;
               state   <= LOCK;
            end
            LOCK: if (release_lock) begin
               o_grant    <= '0;
               state      <= IDLE;
               last_owner <= owner_idx;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of AXI-Stream byte sources sharing one emitter (2..16).
REQ-002 Parameter TIMEOUT, default 255, stall-cycle limit for the watchdog (1..65535).
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_tdata  input  8*NUM_SRC  source bytes; source k at bits [8k+7:8k].
REQ-006 i_tlast  input  NUM_SRC  per-source end-of-packet flag.
REQ-007 i_tvalid  input  NUM_SRC  per-source valid.
REQ-008 o_tready  output  NUM_SRC  per-source ready.
REQ-009 o_tdata  output  8  byte to emitter.
REQ-010 o_tlast  output  1  end-of-packet to emitter.
REQ-011 o_tvalid  output  1  valid to emitter.
REQ-012 i_tready  input  1  ready from emitter.
REQ-013 o_grant  output  NUM_SRC  one-hot current owner; all-zero when idle.
REQ-014 o_timeout  output  1  one-cycle pulse on watchdog release.

Function
REQ-015 Two-state FSM: IDLE (no owner), LOCK (one owner until its tlast beat is accepted).
REQ-016 IDLE: if any i_tvalid bit set, register a winner into o_grant and enter LOCK next cycle; arbitration latency exactly 1 cycle; no beat passes in IDLE.
REQ-017 Winner is round-robin: first valid source searching upward (with wrap from NUM_SRC-1 to 0) from index last_owner+1.
REQ-018 last_owner updates only on completion of a packet or watchdog release.
REQ-019 LOCK: o_tdata/o_tlast/o_tvalid combinationally equal the owner's i_tdata/i_tlast/i_tvalid; o_tready[owner] = i_tready; all other o_tready bits 0.
REQ-020 Beat accepted when o_tvalid && i_tready; accepted beat with o_tlast=1 returns FSM to IDLE next cycle and clears o_grant.
REQ-021 Single-beat packet (tlast on first beat) is legal: LOCK lasts one cycle.
REQ-022 Owner deasserting tvalid mid-packet keeps LOCK; non-owner tvalid is ignored until IDLE.
REQ-023 Sole persistent requester is re-granted after its 1 IDLE cycle; per-packet overhead exactly 1 cycle.
REQ-024 In IDLE o_tvalid=0, o_tlast=0, o_tdata=0, o_tready all 0.

Reset
REQ-025 i_rst_n low forces IDLE, o_grant=0, last_owner=NUM_SRC-1 (so source 0 wins first), watchdog count 0, o_timeout=0, immediately and asynchronously.
REQ-026 Reset mid-packet abandons the packet; no partial-packet recovery; first arbitration after release follows REQ-025 priority.

Configuration
REQ-027 Macro PACKET_ARBITER_WATCHDOG_EN: when defined, a counter increments each LOCK cycle without an accepted beat, clears on any accepted beat; on reaching TIMEOUT the FSM returns to IDLE, o_grant clears, last_owner becomes the stalled owner, o_timeout pulses one cycle.
REQ-028 Stalls caused by i_tready=0 with owner tvalid=1 do not count.
REQ-029 Without the macro: no counter logic, o_timeout tied 0, LOCK held indefinitely.

Structure
REQ-030 Shared package packet_arbiter_pkg holds the FSM state enum (IDLE, LOCK) and the default NUM_SRC/TIMEOUT constants.
REQ-031 One sub-module rr_pick: combinational round-robin one-hot picker (request vector, last_owner index -> one-hot grant, any flag).

Verification
REQ-032 NUM_SRC=4, all four sources offer 3-byte packets simultaneously, i_tready=1 -> packets emerge in order 0,1,2,3, each preceded by exactly one idle cycle, 16 total cycles.
REQ-033 Source 2 sends 0xA5 single-beat packet, i_tready toggling 0/1 -> byte held stable while i_tready=0, accepted once, o_grant=4'b0100 for the LOCK cycles only.
REQ-034 Source 1 mid-packet, source 3 raises tvalid -> source 3 sees o_tready=0 until source 1's tlast is accepted, then granted after 1 IDLE cycle.
REQ-035 i_rst_n pulsed low during byte 2 of a 4-byte packet -> o_grant=0 and o_tvalid=0 same cycle; after release source 0 wins first.
REQ-036 With PACKET_ARBITER_WATCHDOG_EN, TIMEOUT=8, owner drops tvalid for 8 cycles -> o_timeout high exactly one cycle, FSM IDLE, next valid source granted; without macro, same stimulus holds LOCK and o_timeout stays 0.
